pipeline_control_unit: RTL and testbench

- Central sequencer for the 5-stage pipeline around the decode stage and its ID/EXE register.
- Detects RAW hazards between decode sources and EXE/MEM destinations, and squashes wrong-path instructions on taken branches.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a timeout error state.
- Drives the PC/IF freeze, the IF/ID flush and the ID/EXE flush (the decode block's `flush` input); keeps saturating stall/flush performance counters.

---
 rtl/pipeline_control_unit_if.sv | 46 ++++
 rtl/pipeline_control_unit.sv | 130 +++++++++++++
 tb/tb_pipeline_control_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_if.sv
// Decode-side hazard/memory status in, pipeline freeze/flush controls and perf counters out.
// master is the pipeline/testbench side that drives status; slave is the control unit.
interface pipeline_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             forward_en;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             src1_valid;
  logic             two_src;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             err_clear;
  logic             cnt_clear;

  logic             pc_freeze;
  logic             if_flush;
  logic             id_flush;
  logic             exe_freeze;
  logic             mem_freeze;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output forward_en, src1, src2, src1_valid, two_src,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready, err_clear, cnt_clear,
    input  pc_freeze, if_flush, id_flush, exe_freeze, mem_freeze,
           mem_error, stall_cnt, flush_cnt
  );

  modport slave (
    input  forward_en, src1, src2, src1_valid, two_src,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready, err_clear, cnt_clear,
    output pc_freeze, if_flush, id_flush, exe_freeze, mem_freeze,
           mem_error, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: RAW hazard stalls, branch squash, memory-wait freeze with timeout error.
// Freeze/flush outputs are combinational (0 cycles); state/counters update on the next edge; a busy memory freezes every stage.
module pipeline_control_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_control_unit_if.slave pcu
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_error_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic match_exe;
  logic match_mem;
  logic data_hazard;
  logic mem_busy;
  logic frozen;
  logic branch_flush;

  always_comb begin
    match_exe = pcu.exe_wb_en &
                ((pcu.src1_valid & (pcu.src1 == pcu.exe_dest)) |
                 (pcu.two_src    & (pcu.src2 == pcu.exe_dest)));
    match_mem = pcu.mem_wb_en &
                ((pcu.src1_valid & (pcu.src1 == pcu.mem_dest)) |
                 (pcu.two_src    & (pcu.src2 == pcu.mem_dest)));
    // With forwarding only a load in EXE cannot be bypassed in time.
    data_hazard = pcu.forward_en ? (match_exe & pcu.exe_mem_read)
                                 : (match_exe | match_mem);
    mem_busy = pcu.mem_req & ~pcu.mem_ready;
    frozen   = (state == MEM_ERR) | mem_busy;

    pcu.pc_freeze  = 1'b0;
    pcu.if_flush   = 1'b0;
    pcu.id_flush   = 1'b0;
    pcu.exe_freeze = 1'b0;
    pcu.mem_freeze = 1'b0;
    branch_flush   = 1'b0;

    if (!rst) begin
      pcu.if_flush = 1'b1;
      pcu.id_flush = 1'b1;
    end else if (frozen) begin
      // A taken branch stays parked in the frozen EXE stage until release.
      pcu.pc_freeze  = 1'b1;
      pcu.exe_freeze = 1'b1;
      pcu.mem_freeze = 1'b1;
    end else if (pcu.branch_taken) begin
      pcu.if_flush = 1'b1;
      pcu.id_flush = 1'b1;
      branch_flush = 1'b1;
    end else if (data_hazard) begin
      pcu.pc_freeze = 1'b1;
      pcu.id_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_error_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // Completion and an aborted request both release without error.
          if (!mem_busy) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= MEM_ERR;
            wait_cnt    <= '0;
            mem_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        MEM_ERR: begin
          if (pcu.err_clear) begin
            state       <= RUN;
            mem_error_q <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (pcu.cnt_clear) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pcu.pc_freeze && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_W'(1);
      if (branch_flush && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign pcu.mem_error = mem_error_q;
  assign pcu.stall_cnt = stall_q;
  assign pcu.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: two instances (default timeout/16-bit counters and 4-cycle timeout/4-bit counters)
// share one stimulus stream; a cycle-level model is compared every negedge, plus literal checks at key points.
module tb_pipeline_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(16)) ifa ();
  pipeline_control_unit_if #(.CNT_W(4))  ifb ();

  pipeline_control_unit #(.MEM_TIMEOUT(64), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .pcu(ifa.slave));
  pipeline_control_unit #(.MEM_TIMEOUT(4),  .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .pcu(ifb.slave));

  assign ifb.forward_en   = ifa.forward_en;
  assign ifb.src1         = ifa.src1;
  assign ifb.src2         = ifa.src2;
  assign ifb.src1_valid   = ifa.src1_valid;
  assign ifb.two_src      = ifa.two_src;
  assign ifb.exe_dest     = ifa.exe_dest;
  assign ifb.exe_wb_en    = ifa.exe_wb_en;
  assign ifb.exe_mem_read = ifa.exe_mem_read;
  assign ifb.mem_dest     = ifa.mem_dest;
  assign ifb.mem_wb_en    = ifa.mem_wb_en;
  assign ifb.branch_taken = ifa.branch_taken;
  assign ifb.mem_req      = ifa.mem_req;
  assign ifb.mem_ready    = ifa.mem_ready;
  assign ifb.err_clear    = ifa.err_clear;
  assign ifb.cnt_clear    = ifa.cnt_clear;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Control word packing used everywhere: {pc_freeze, if_flush, id_flush, exe_freeze, mem_freeze}.
  function automatic logic [4:0] exp_ctl(input bit err);
    logic me, mm, hz;
    me = ifa.exe_wb_en && ((ifa.src1_valid && ifa.src1 == ifa.exe_dest) ||
                           (ifa.two_src && ifa.src2 == ifa.exe_dest));
    mm = ifa.mem_wb_en && ((ifa.src1_valid && ifa.src1 == ifa.mem_dest) ||
                           (ifa.two_src && ifa.src2 == ifa.mem_dest));
    hz = ifa.forward_en ? (me && ifa.exe_mem_read) : (me || mm);
    if (!rst) return 5'b01100;
    if (err || (ifa.mem_req && !ifa.mem_ready)) return 5'b10011;
    if (ifa.branch_taken) return 5'b01100;
    if (hz) return 5'b10100;
    return 5'b00000;
  endfunction

  function automatic bit exp_pc_freeze(input bit err);
    logic [4:0] v;
    v = exp_ctl(err);
    return v[4];
  endfunction

  function automatic bit exp_branch_flush(input bit err);
    return rst && !err && !(ifa.mem_req && !ifa.mem_ready) && ifa.branch_taken;
  endfunction

  function automatic int to_of(input int i);
    return (i == 0) ? 64 : 4;
  endfunction

  function automatic int sat_of(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  // Model: an error flag, a run length of consecutive busy cycles, and two saturating counts.
  bit m_err[2];
  int m_waited[2];
  int m_stall[2];
  int m_flush[2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_err[i] <= 1'b0; m_waited[i] <= 0; m_stall[i] <= 0; m_flush[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ifa.cnt_clear) begin
          m_stall[i] <= 0;
          m_flush[i] <= 0;
        end else begin
          if (exp_pc_freeze(m_err[i]) && m_stall[i] < sat_of(i)) m_stall[i] <= m_stall[i] + 1;
          if (exp_branch_flush(m_err[i]) && m_flush[i] < sat_of(i)) m_flush[i] <= m_flush[i] + 1;
        end
        if (m_err[i]) begin
          if (ifa.err_clear) m_err[i] <= 1'b0;
        end else if (ifa.mem_req && !ifa.mem_ready) begin
          if (m_waited[i] + 1 >= to_of(i)) begin
            m_err[i] <= 1'b1;
            m_waited[i] <= 0;
          end else begin
            m_waited[i] <= m_waited[i] + 1;
          end
        end else begin
          m_waited[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ctl_a", 32'({ifa.pc_freeze, ifa.if_flush, ifa.id_flush, ifa.exe_freeze, ifa.mem_freeze, ifa.mem_error}),
          32'({exp_ctl(m_err[0]), m_err[0]}));
    check("ctl_b", 32'({ifb.pc_freeze, ifb.if_flush, ifb.id_flush, ifb.exe_freeze, ifb.mem_freeze, ifb.mem_error}),
          32'({exp_ctl(m_err[1]), m_err[1]}));
    check("stall_a", 32'(ifa.stall_cnt), m_stall[0]);
    check("stall_b", 32'(ifb.stall_cnt), m_stall[1]);
    check("flush_a", 32'(ifa.flush_cnt), m_flush[0]);
    check("flush_b", 32'(ifb.flush_cnt), m_flush[1]);
  end

  // Literal 6-bit views {pc,if,id,exe,mem,err}: 24 flush, 40 hazard stall, 38 frozen, 39 frozen+error.
  function automatic logic [31:0] ctl_of_a();
    return 32'({ifa.pc_freeze, ifa.if_flush, ifa.id_flush, ifa.exe_freeze, ifa.mem_freeze, ifa.mem_error});
  endfunction

  function automatic logic [31:0] ctl_of_b();
    return 32'({ifb.pc_freeze, ifb.if_flush, ifb.id_flush, ifb.exe_freeze, ifb.mem_freeze, ifb.mem_error});
  endfunction

  task automatic clear_in();
    ifa.forward_en = 1'b0; ifa.src1 = 4'd0; ifa.src2 = 4'd0; ifa.src1_valid = 1'b0;
    ifa.two_src = 1'b0; ifa.exe_dest = 4'd0; ifa.exe_wb_en = 1'b0; ifa.exe_mem_read = 1'b0;
    ifa.mem_dest = 4'd0; ifa.mem_wb_en = 1'b0; ifa.branch_taken = 1'b0; ifa.mem_req = 1'b0;
    ifa.mem_ready = 1'b0; ifa.err_clear = 1'b0; ifa.cnt_clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ifa.forward_en = 1'b1; ifa.exe_mem_read = 1'b1; ifa.exe_wb_en = 1'b1;
    ifa.exe_dest = 4'd3; ifa.src1 = 4'd3; ifa.src1_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    step(); step();
    check("reset_ctl", ctl_of_a(), 24);
    check("reset_stall", 32'(ifa.stall_cnt), 0);
    rst = 1'b1;
    step();
    check("idle_ctl", ctl_of_a(), 0);

    // Load-use stall lasts exactly one cycle.
    set_load_use();
    #1 check("load_use_ctl", ctl_of_a(), 40);
    step(); clear_in();
    #1 check("load_use_after", ctl_of_a(), 0);
    check("load_use_stall", 32'(ifa.stall_cnt), 1);

    // MEM-stage hazard only matters without forwarding.
    ifa.mem_wb_en = 1'b1; ifa.mem_dest = 4'd7; ifa.two_src = 1'b1; ifa.src2 = 4'd7;
    #1 check("mem_hz_nofwd", ctl_of_a(), 40);
    step(); ifa.forward_en = 1'b1;
    #1 check("mem_hz_fwd", ctl_of_a(), 0);
    step(); clear_in();
    ifa.exe_wb_en = 1'b1; ifa.exe_dest = 4'd15; ifa.src1 = 4'd15; ifa.src1_valid = 1'b1;
    #1 check("pc_index_hz", ctl_of_a(), 40);
    step(); ifa.src1_valid = 1'b0;
    #1 check("src1_not_read", ctl_of_a(), 0);
    step(); clear_in();

    // Taken branch overrides a load-use hazard.
    set_load_use(); ifa.branch_taken = 1'b1;
    #1 check("branch_over_hz", ctl_of_a(), 24);
    step(); clear_in();
    #1 check("branch_flush_cnt", 32'(ifa.flush_cnt), 1);

    // Five busy cycles with a branch parked in EXE; release flushes on the sixth.
    ifa.mem_req = 1'b1; ifa.branch_taken = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check("mem_wait_frozen", ctl_of_a(), 38);
      step();
    end
    ifa.mem_ready = 1'b1;
    #1 check("mem_release_flush", ctl_of_a(), 24);
    check("b_ignores_ready", ctl_of_b(), 39);
    step(); clear_in(); ifa.err_clear = 1'b1;
    #1 check("after_release", ctl_of_a(), 0);
    check("release_flush_cnt", 32'(ifa.flush_cnt), 2);
    step(); clear_in();
    #1 check("b_cleared", ctl_of_b(), 0);

    // Timeout on the 4-cycle instance.
    ifa.mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check("timeout_wait", ctl_of_b(), 38);
      step();
    end
    #1 check("timeout_err", ctl_of_b(), 39);
    step(); ifa.mem_ready = 1'b1;
    #1 check("err_holds", ctl_of_b(), 39);
    step(); ifa.mem_ready = 1'b0; ifa.mem_req = 1'b0; ifa.err_clear = 1'b1;
    #1 check("err_before_clear", ctl_of_b(), 39);
    step(); clear_in();
    #1 check("err_cleared", ctl_of_b(), 0);

    // Asynchronous reset while waiting on memory.
    ifa.mem_req = 1'b1;
    step(); step();
    #1 rst = 1'b0;
    #1 check("async_rst_ctl_a", ctl_of_a(), 24);
    check("async_rst_ctl_b", ctl_of_b(), 24);
    check("async_rst_stall", 32'(ifa.stall_cnt), 0);
    step(); rst = 1'b1; clear_in();
    step();

    // Saturation of the 4-bit counter, then clear priority over increment.
    ifa.exe_wb_en = 1'b1; ifa.exe_dest = 4'd5; ifa.src1 = 4'd5; ifa.src1_valid = 1'b1;
    repeat (20) step();
    clear_in();
    #1 check("sat_stall_a", 32'(ifa.stall_cnt), 20);
    check("sat_stall_b", 32'(ifb.stall_cnt), 15);
    ifa.exe_wb_en = 1'b1; ifa.exe_dest = 4'd5; ifa.src1 = 4'd5; ifa.src1_valid = 1'b1;
    ifa.cnt_clear = 1'b1;
    step(); clear_in();
    #1 check("cnt_clear_a", 32'(ifa.stall_cnt), 0);
    check("cnt_clear_b", 32'(ifb.stall_cnt), 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
